// File: rtl/riscv_dram_pkg.sv
// Shared types and width helpers for the block-wide DRAM model.
package riscv_dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dram_state_e;

  // Latency counter holds LATENCY-1, LATENCY is at most 255.
  localparam int unsigned CNT_W = 8;

  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/riscv_dram_lane.sv
// One byte lane of the block memory: synchronous write, registered synchronous read.
module riscv_dram_lane #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  (* ram_style = "block" *) logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/riscv_dram_model.sv
// Block-wide data DRAM model: one request at a time, programmable access latency,
// per-byte write strobes and a held response with back-pressure.
module riscv_dram_model
  import riscv_dram_pkg::*;
#(
  parameter int unsigned DATAPBLOCK = 16,
  parameter int unsigned DATA_WIDTH = 8 * DATAPBLOCK,
  parameter int unsigned MEM_SIZE   = 16384,
  parameter int unsigned MEM_DEPTH  = MEM_SIZE / DATAPBLOCK,
  parameter int unsigned S_ADDR     = addr_bits(MEM_DEPTH),
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [S_ADDR-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATAPBLOCK-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  dram_state_e           state_q;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_we_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATAPBLOCK-1:0] wstrb_q;

  logic                  commit_c;
  logic [S_ADDR-1:0]     lane_addr_c;
  logic [DATA_WIDTH-1:0] lane_rdata_c;

  assign commit_c = (state_q == ST_WAIT) && (cnt_q == '0);
  // Address the lanes from the request port while idle so a LATENCY=1 read has data by commit.
  assign lane_addr_c = (state_q == ST_IDLE) ? req_addr : addr_q;

  for (genvar i = 0; i < DATAPBLOCK; i++) begin : g_lane
    riscv_dram_lane #(
      .DEPTH (MEM_DEPTH),
      .AW    (S_ADDR)
    ) u_lane (
      .clk     (clk),
      .we_i    (commit_c && we_q && wstrb_q[i]),
      .addr_i  (lane_addr_c),
      .wdata_i (wdata_q[8*i +: 8]),
      .rdata_o (lane_rdata_c[8*i +: 8])
    );
  end

  // Request/response FSM with latency counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            cnt_q   <= CNT_W'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            if (!we_q) begin
              rsp_rdata_q <= lane_rdata_c;
            end
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_riscv_dram_model.sv
// Bench for riscv_dram_model: a LATENCY=4 and a LATENCY=1 instance checked every cycle
// against a timestamp-based transaction model, plus directed literal checks.
module tb_riscv_dram_model;

  localparam int unsigned NB    = 16;
  localparam int unsigned DW    = 8 * NB;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk;
  logic          rst_n;
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic [NB-1:0] req_wstrb [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic          rsp_we    [2];
  logic [DW-1:0] rsp_rdata [2];

  riscv_dram_model #(.DATAPBLOCK(NB), .MEM_SIZE(DEPTH * NB), .LATENCY(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]),
    .rsp_rdata(rsp_rdata[0])
  );

  riscv_dram_model #(.DATAPBLOCK(NB), .MEM_SIZE(DEPTH * NB), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]),
    .rsp_rdata(rsp_rdata[1])
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  bit          run_chk = 1'b0;

  // Transaction-level model: pending request with due cycle, held response, byte memory image.
  bit            m_busy [2];
  bit            m_rv   [2];
  logic          m_rwe  [2];
  logic [DW-1:0] m_rd   [2];
  int unsigned   m_due  [2];
  logic          m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd   [2];
  logic [NB-1:0] m_st   [2];
  logic [DW-1:0] mem_m  [2][DEPTH];

  function automatic int unsigned lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NB-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] pick(input int unsigned i);
    return (i < 8) ? AW'(i) : AW'(DEPTH - 16 + i);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_rv[d]   = 1'b0;
      m_rwe[d]  = 1'b0;
      m_rd[d]   = '0;
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(negedge rst_n);
    model_clear();
  end

  // Model advance on every rising edge, using the inputs present at that edge.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (m_rv[d]) begin
          if (rsp_ready[d]) m_rv[d] = 1'b0;
        end else if (m_busy[d]) begin
          if (cyc == m_due[d]) begin
            m_busy[d] = 1'b0;
            m_rv[d]   = 1'b1;
            m_rwe[d]  = m_we[d];
            if (m_we[d]) mem_m[d][m_addr[d]] = merge(mem_m[d][m_addr[d]], m_wd[d], m_st[d]);
            else         m_rd[d] = mem_m[d][m_addr[d]];
          end
        end else if (req_valid[d]) begin
          m_busy[d] = 1'b1;
          m_due[d]  = cyc + lat(d);
          m_we[d]   = req_we[d];
          m_addr[d] = req_addr[d];
          m_wd[d]   = req_wdata[d];
          m_st[d]   = req_wstrb[d];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (run_chk && rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("req_ready_d%0d", d), DW'(req_ready[d]), DW'(!m_busy[d] && !m_rv[d]));
        chk($sformatf("rsp_valid_d%0d", d), DW'(rsp_valid[d]), DW'(m_rv[d]));
        chk($sformatf("rsp_we_d%0d", d), DW'(rsp_we[d]), DW'(m_rwe[d]));
        chk($sformatf("rsp_rdata_d%0d", d), rsp_rdata[d], m_rd[d]);
      end
    end
  end

  // One request/response transaction; starts and ends on a falling edge.
  task automatic do_req(input int d, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [NB-1:0] st, input bit bp,
                        output int unsigned acc, output int unsigned rise,
                        output int unsigned done, output logic rwe, output logic [DW-1:0] rd);
    int k;
    bit go;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("ready_wait_d%0d", d), DW'(req_ready[d]), DW'(1'b1));
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = st;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    acc = cyc;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom_range(0, 1));
    req_addr[d]  = AW'($urandom);
    req_wdata[d] = rnd128();
    req_wstrb[d] = NB'($urandom);
    k = 0;
    while (!rsp_valid[d] && k < 300) begin
      req_valid[d] = ($urandom_range(0, 3) == 0);
      rsp_ready[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      k++;
    end
    req_valid[d] = 1'b0;
    chk($sformatf("rsp_wait_d%0d", d), DW'(rsp_valid[d]), DW'(1'b1));
    rise = cyc;
    rwe  = rsp_we[d];
    rd   = rsp_rdata[d];
    k = 0;
    do begin
      go = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      rsp_ready[d] = go;
      @(negedge clk);
      k++;
    end while (!go && k < 100);
    rsp_ready[d] = 1'b1;
    done = cyc;
  endtask

  task automatic prefill(input int d);
    int unsigned acc, rise, done;
    logic rwe;
    logic [DW-1:0] rd;
    for (int unsigned i = 0; i < 16; i++) begin
      do_req(d, 1'b1, pick(i), rnd128(), '1, 1'b0, acc, rise, done, rwe, rd);
    end
  endtask

  task automatic rand_run(input int d);
    int unsigned acc, rise, done, r;
    logic rwe;
    logic [DW-1:0] rd;
    logic [NB-1:0] st;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 7);
      st = (r == 0) ? '0 : (r == 1) ? '1 : NB'($urandom);
      do_req(d, 1'($urandom_range(0, 1)), pick($urandom_range(0, 15)), rnd128(), st, 1'b1,
             acc, rise, done, rwe, rd);
      chk($sformatf("rand_lat_d%0d", d), DW'(rise - acc), DW'(lat(d)));
    end
  endtask

  initial begin
    logic [DW-1:0] d1, p3, rd, z;
    int unsigned acc, acc2, rise, done;
    logic rwe;
    int k;
    d1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    p3 = 128'h00112233_44556677_8899AABB_A5A5A5A5;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < DEPTH; a++) mem_m[d][a] = '0;
    end
    model_clear();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wstrb[d] = '0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_d%0d", d), DW'(req_ready[d]), DW'(1'b1));
      chk($sformatf("reset_valid_d%0d", d), DW'(rsp_valid[d]), DW'(1'b0));
      chk($sformatf("reset_we_d%0d", d), DW'(rsp_we[d]), DW'(1'b0));
      chk($sformatf("reset_rdata_d%0d", d), rsp_rdata[d], '0);
    end
    #2 rst_n = 1'b1;
    run_chk = 1'b1;
    @(negedge clk);

    // Full write, response 4 edges after accept, held one cycle.
    do_req(0, 1'b1, AW'(10'h010), d1, '1, 1'b0, acc, rise, done, rwe, rd);
    chk("t1_latency", DW'(rise - acc), DW'(4));
    chk("t1_rsp_we", DW'(rwe), DW'(1'b1));
    chk("t1_held", DW'(done - rise), DW'(1));
    chk("t1_ready_back", DW'(req_ready[0]), DW'(1'b1));

    do_req(0, 1'b0, AW'(10'h010), '0, '0, 1'b0, acc, rise, done, rwe, rd);
    chk("t2_rdata", rd, d1);
    chk("t2_rsp_we", DW'(rwe), DW'(1'b0));

    do_req(0, 1'b1, AW'(10'h010), {NB{8'hA5}}, NB'(16'h000F), 1'b0, acc, rise, done, rwe, rd);
    do_req(0, 1'b0, AW'(10'h010), '0, '0, 1'b0, acc, rise, done, rwe, rd);
    chk("t3_rdata", rd, p3);

    // Back-pressured read with ignored request pulses.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = AW'(10'h010); rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    k = 0;
    while (!rsp_valid[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t4_valid", DW'(rsp_valid[0]), DW'(1'b1));
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wstrb[0] = '1; req_wdata[0] = rnd128();
      @(negedge clk);
      chk("t4_hold_valid", DW'(rsp_valid[0]), DW'(1'b1));
      chk("t4_hold_rdata", rsp_rdata[0], p3);
      chk("t4_ready_low", DW'(req_ready[0]), DW'(1'b0));
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t4_released", DW'(rsp_valid[0]), DW'(1'b0));
    chk("t4_idle", DW'(req_ready[0]), DW'(1'b1));
    do_req(0, 1'b0, AW'(10'h010), '0, '0, 1'b0, acc, rise, done, rwe, rd);
    chk("t4_no_corrupt", rd, p3);

    // LATENCY=1: accept-to-accept is L+2 edges (L+1 non-accepting cycles between accepts).
    z = rnd128();
    do_req(1, 1'b1, '0, z, '1, 1'b0, acc, rise, done, rwe, rd);
    chk("t5_wr_latency", DW'(rise - acc), DW'(1));
    do_req(1, 1'b0, '0, '0, '0, 1'b0, acc2, rise, done, rwe, rd);
    chk("t5_rd_latency", DW'(rise - acc2), DW'(1));
    chk("t5_spacing", DW'(acc2 - acc), DW'(3));
    chk("t5_rdata", rd, z);

    // Reset during WAIT drops the write.
    do_req(0, 1'b1, AW'(10'h020), '0, '1, 1'b0, acc, rise, done, rwe, rd);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = AW'(10'h020);
    req_wdata[0] = '1; req_wstrb[0] = '1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_low", DW'(rsp_valid[0]), DW'(1'b0));
    chk("t6_ready_high", DW'(req_ready[0]), DW'(1'b1));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_req(0, 1'b0, AW'(10'h020), '0, '0, 1'b0, acc, rise, done, rwe, rd);
    chk("t6_not_committed", rd, '0);

    fork
      prefill(0);
      prefill(1);
    join
    fork
      rand_run(0);
      rand_run(1);
    join

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
